// File: rtl/regfile_dumper.sv
`default_nettype none
// regfile_dumper: walks regfile entries FIRST_REG..LAST_REG through one read port, streaming each word on valid/ready.
// Define REGFILE_DUMP_CHECKSUM_EN to append an XOR checksum word after the last register.
module regfile_dumper #(
    parameter int unsigned FIRST_REG = 0,
    parameter int unsigned LAST_REG  = 31
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [4:0]  rd_addr,
    input  logic [31:0] rd_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [4:0]  out_idx,
    output logic        out_last,
    output logic        out_csum
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_SEND  = 3'd2,
        S_CSUM  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [4:0] FIRST_IDX = 5'(FIRST_REG);
    localparam logic [4:0] LAST_IDX  = 5'(LAST_REG);
`ifdef REGFILE_DUMP_CHECKSUM_EN
    localparam logic CSUM_EN = 1'b1;
`else
    localparam logic CSUM_EN = 1'b0;
`endif

    state_t      state_q, state_d;
    logic [4:0]  idx_q, idx_d;
    logic [31:0] data_q, data_d;
    logic [4:0]  oidx_q, oidx_d;
    logic        last_q, last_d;
    logic        is_last_reg;

`ifdef REGFILE_DUMP_CHECKSUM_EN
    logic [31:0] acc_q, acc_d;
    logic        csum_q, csum_d;
    // CSUM spends one cycle loading the accumulator before presenting it
    logic        csum_vld_q, csum_vld_d;
`endif

    assign is_last_reg = (idx_q == LAST_IDX);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            idx_q      <= 5'd0;
            data_q     <= 32'd0;
            oidx_q     <= 5'd0;
            last_q     <= 1'b0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
            acc_q      <= 32'd0;
            csum_q     <= 1'b0;
            csum_vld_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            data_q     <= data_d;
            oidx_q     <= oidx_d;
            last_q     <= last_d;
`ifdef REGFILE_DUMP_CHECKSUM_EN
            acc_q      <= acc_d;
            csum_q     <= csum_d;
            csum_vld_q <= csum_vld_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        data_d  = data_q;
        oidx_d  = oidx_q;
        last_d  = last_q;
`ifdef REGFILE_DUMP_CHECKSUM_EN
        acc_d      = acc_q;
        csum_d     = csum_q;
        csum_vld_d = csum_vld_q;
`endif
        case (state_q)
            S_IDLE: begin
                idx_d = FIRST_IDX;
                if (start) begin
                    state_d = S_FETCH;
`ifdef REGFILE_DUMP_CHECKSUM_EN
                    acc_d   = 32'd0;
`endif
                end
            end
            S_FETCH: begin
                // Snapshot: a regfile write landing on this same edge is not seen
                data_d  = rd_data;
                oidx_d  = idx_q;
                last_d  = is_last_reg && !CSUM_EN;
`ifdef REGFILE_DUMP_CHECKSUM_EN
                csum_d  = 1'b0;
`endif
                state_d = S_SEND;
            end
            S_SEND: begin
                if (out_ready) begin
`ifdef REGFILE_DUMP_CHECKSUM_EN
                    acc_d = acc_q ^ data_q;
`endif
                    if (is_last_reg) begin
                        state_d = CSUM_EN ? S_CSUM : S_DONE;
                    end else begin
                        idx_d   = idx_q + 5'd1;
                        state_d = S_FETCH;
                    end
                end
            end
`ifdef REGFILE_DUMP_CHECKSUM_EN
            S_CSUM: begin
                if (!csum_vld_q) begin
                    data_d     = acc_q;
                    oidx_d     = 5'd0;
                    last_d     = 1'b1;
                    csum_d     = 1'b1;
                    csum_vld_d = 1'b1;
                end else if (out_ready) begin
                    csum_vld_d = 1'b0;
                    state_d    = S_DONE;
                end
            end
`endif
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign rd_addr  = idx_q;
    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_DONE);
    assign out_data = data_q;
    assign out_idx  = oidx_q;
    assign out_last = last_q;
`ifdef REGFILE_DUMP_CHECKSUM_EN
    assign out_valid = (state_q == S_SEND) || ((state_q == S_CSUM) && csum_vld_q);
    assign out_csum  = csum_q;
`else
    assign out_valid = (state_q == S_SEND);
    assign out_csum  = 1'b0;
`endif

endmodule
`default_nettype wire
